// File: rtl/button_ce_gen.sv
// button_ce_gen: turns raw bouncing push-buttons into debounced levels, one-cycle press pulses
// and a run/stop ce level (button 1 stops, button 0 toggles).
module button_ce_gen #(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] buttons_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise_pulse,
    output logic             ce
);
    localparam int TW = $clog2(SAMPLE_CNT_MAX);
    localparam int CW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(PULSE_CNT_MAX);
    logic [WIDTH-1:0]         meta, sync, deb_d;
    logic [TW-1:0]            timer;
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic                     sample_tick;
    assign sample_tick = timer == TIMER_LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= '0;
            sync  <= '0;
            timer <= '0;
            deb_d <= '0;
            ce    <= 1'b0;
        end else begin
            meta  <= buttons_in;
            sync  <= meta;
            timer <= sample_tick ? '0 : timer + 1'b1;
            deb_d <= debounced;
            ce    <= rise_pulse[1] ? 1'b0 : rise_pulse[0] ? ~ce : ce;
        end
    end
    // any low sample restarts qualification; counters saturate instead of wrapping
    always_ff @(posedge clk) begin
        for (int j = 0; j < WIDTH; j++)
            cnt[j] <= (rst || !sync[j]) ? '0 :
                      (sample_tick && cnt[j] < CNT_FULL) ? cnt[j] + 1'b1 : cnt[j];
    end
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_deb
        assign debounced[i] = cnt[i] == CNT_FULL;
    end
    assign rise_pulse = debounced & ~deb_d;
endmodule

// File: tb/tb_button_ce_gen.sv
// tb_button_ce_gen: directed checks of reset, press, bounce, release, simultaneous press
// and mid-hold reset, with expected output states queued and compared at negedges.
module tb_button_ce_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] buttons_in = 4'b1111;
    logic [3:0] debounced, rise_pulse;
    logic       ce;
    int         checks = 0, errors = 0;
    int         n, pulses, highs;

    typedef struct {
        string      tag;
        logic [3:0] deb;
        logic [3:0] rise;
        logic       ce;
    } exp_t;
    exp_t sbq[$];

    button_ce_gen #(.WIDTH(4), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)) dut (
        .clk(clk), .rst(rst), .buttons_in(buttons_in),
        .debounced(debounced), .rise_pulse(rise_pulse), .ce(ce)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] d, input logic [3:0] r, input logic c);
        sbq.push_back('{tag, d, r, c});
    endtask

    task automatic compare();
        exp_t e;
        e = sbq.pop_front();
        checks++;
        assert (debounced === e.deb && rise_pulse === e.rise && ce === e.ce)
        else begin
            errors++;
            $error("FAIL %s: got deb=%b rise=%b ce=%b expected deb=%b rise=%b ce=%b",
                   e.tag, debounced, rise_pulse, ce, e.deb, e.rise, e.ce);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_deb0(input int maxn, output int cnt_edges);
        cnt_edges = 0;
        while (!debounced[0] && cnt_edges < maxn) begin
            @(negedge clk);
            cnt_edges++;
        end
    endtask

    initial begin
        // reset with all buttons pressed
        for (int k = 0; k < 3; k++) begin
            push("reset_out", 4'b0000, 4'b0000, 1'b0);
            @(negedge clk);
            compare();
            chk("reset_timer", int'(dut.timer), 0);
            chk("reset_cnt", int'(dut.cnt), 0);
        end
        // clean press right after reset: timer phase is known, so latency is exact
        rst = 1'b0;
        buttons_in = 4'b0001;
        wait_deb0(20, n);
        chk("press1_latency", n, 12);
        push("press1_pulse", 4'b0001, 4'b0001, 1'b0);
        compare();
        @(negedge clk);
        push("press1_ce", 4'b0001, 4'b0000, 1'b1);
        compare();
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            pulses += int'(rise_pulse[0]);
        end
        chk("hold_no_repeat", pulses, 0);
        push("hold_state", 4'b0001, 4'b0000, 1'b1);
        compare();
        buttons_in = 4'b0000;
        repeat (6) @(negedge clk);
        push("release1", 4'b0000, 4'b0000, 1'b1);
        compare();
        // bounce: high runs of 3 cycles can never span 3 sample ticks
        pulses = 0;
        highs  = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) buttons_in[0] = ~buttons_in[0];
            @(negedge clk);
            pulses += int'(rise_pulse[0]);
            highs  += int'(debounced[0]);
        end
        buttons_in[0] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(rise_pulse[0]);
            highs  += int'(debounced[0]);
        end
        chk("bounce_pulses", pulses, 0);
        chk("bounce_deb_high", highs, 0);
        push("bounce_end", 4'b0000, 4'b0000, 1'b1);
        compare();
        // second press stops, then release latency
        buttons_in = 4'b0001;
        wait_deb0(20, n);
        chk_range("press2_latency", n, 11, 14);
        push("press2_pulse", 4'b0001, 4'b0001, 1'b1);
        compare();
        @(negedge clk);
        push("press2_ce", 4'b0001, 4'b0000, 1'b0);
        compare();
        repeat (5) @(negedge clk);
        buttons_in = 4'b0000;
        @(negedge clk);
        push("rel_edge1", 4'b0001, 4'b0000, 1'b0);
        compare();
        @(negedge clk);
        push("rel_edge2", 4'b0001, 4'b0000, 1'b0);
        compare();
        @(negedge clk);
        push("rel_edge3", 4'b0000, 4'b0000, 1'b0);
        compare();
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(rise_pulse != 4'b0000);
        end
        chk("release_no_pulse", pulses, 0);
        // bring ce to 1, then press 0 and 1 together
        buttons_in = 4'b0001;
        wait_deb0(20, n);
        chk_range("setup_latency", n, 11, 14);
        @(negedge clk);
        push("setup_ce", 4'b0001, 4'b0000, 1'b1);
        compare();
        buttons_in = 4'b0000;
        repeat (6) @(negedge clk);
        buttons_in = 4'b0011;
        wait_deb0(20, n);
        push("simul1_pulse", 4'b0011, 4'b0011, 1'b1);
        compare();
        @(negedge clk);
        push("simul1_ce", 4'b0011, 4'b0000, 1'b0);
        compare();
        buttons_in = 4'b0000;
        repeat (6) @(negedge clk);
        buttons_in = 4'b0011;
        wait_deb0(20, n);
        push("simul0_pulse", 4'b0011, 4'b0011, 1'b0);
        compare();
        @(negedge clk);
        push("simul0_ce", 4'b0011, 4'b0000, 1'b0);
        compare();
        buttons_in = 4'b0000;
        repeat (6) @(negedge clk);
        // reset while channel 0 is partly qualified, button kept held
        buttons_in = 4'b0001;
        n = 0;
        while (dut.cnt[0] != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_cnt2", int'(dut.cnt[0]), 2);
        rst = 1'b1;
        @(negedge clk);
        push("midrst_out", 4'b0000, 4'b0000, 1'b0);
        compare();
        chk("midrst_cnt", int'(dut.cnt), 0);
        rst = 1'b0;
        wait_deb0(20, n);
        chk_range("requal_latency", n, 9, 14);
        push("requal_pulse", 4'b0001, 4'b0001, 1'b0);
        compare();
        @(negedge clk);
        push("requal_ce", 4'b0001, 4'b0000, 1'b1);
        compare();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
